// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags 1..2^ROB_LOG-1 at issue, captures CDB
// results, retires in program order and raises a one-cycle flush on a mispredicted branch.
`ifndef ROB_LOG
`define ROB_LOG 4
`endif

module reorder_buffer #(
    parameter int ROB_LOG = `ROB_LOG
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               issue_valid,
    input  logic [4:0]         issue_rd,
    input  logic               issue_is_branch,
    output logic               rob_full,
    output logic               rename_valid,
    output logic [ROB_LOG-1:0] issue_RobId,
    input  logic               cdb_valid,
    input  logic [ROB_LOG-1:0] cdb_RobId,
    input  logic [31:0]        cdb_value,
    input  logic               cdb_mispredict,
    input  logic [31:0]        cdb_target,
    input  logic [ROB_LOG-1:0] qj_RobId,
    input  logic [ROB_LOG-1:0] qk_RobId,
    output logic               qj_ready,
    output logic [31:0]        qj_value,
    output logic               qk_ready,
    output logic [31:0]        qk_value,
    output logic               commit_valid,
    output logic [4:0]         commit_dest,
    output logic [31:0]        commit_value,
    output logic [ROB_LOG-1:0] commit_RobId,
    output logic               jump_flag,
    output logic [31:0]        jump_pc
);

    localparam int DEPTH = 1 << ROB_LOG;
    localparam logic [ROB_LOG-1:0] PTR_MAX  = {ROB_LOG{1'b1}};
    localparam logic [ROB_LOG-1:0] PTR_ONE  = {{(ROB_LOG-1){1'b0}}, 1'b1};
    localparam logic [ROB_LOG-1:0] PTR_ZERO = {ROB_LOG{1'b0}};

    logic [DEPTH-1:0]   busy_r;
    logic [DEPTH-1:0]   ready_r;
    logic [DEPTH-1:0]   br_r;
    logic [DEPTH-1:0]   mp_r;
    logic [4:0]         rd_r    [DEPTH];
    logic [31:0]        value_r [DEPTH];
    logic [31:0]        tgt_r   [DEPTH];
    logic [ROB_LOG-1:0] head_r;
    logic [ROB_LOG-1:0] tail_r;
    logic [ROB_LOG-1:0] count_r;
    logic               flush_pend_r;
    logic [31:0]        flush_pc_r;
    logic               commit_s;

    // Tag 0 means "not renamed", so pointers wrap from the maximum back to 1.
    function automatic logic [ROB_LOG-1:0] ptr_next(input logic [ROB_LOG-1:0] p);
        return (p == PTR_MAX) ? PTR_ONE : p + PTR_ONE;
    endfunction

    function automatic logic [32:0] query(input logic [ROB_LOG-1:0] tag);
        logic [32:0] res;
        if (tag == PTR_ZERO) begin
            res = {1'b0, 32'h0000_0000};
        end else if (busy_r[tag] && ready_r[tag]) begin
            res = {1'b1, value_r[tag]};
        end else if (cdb_valid && (cdb_RobId == tag)) begin
            res = {1'b1, cdb_value};
        end else begin
            res = {1'b0, 32'h0000_0000};
        end
        return res;
    endfunction

    assign rob_full     = (count_r == PTR_MAX) | flush_pend_r | jump_flag;
    assign rename_valid = issue_valid & ~rob_full;
    assign issue_RobId  = tail_r;

    // Retire eligibility of the head entry and operand lookups.
    always_comb begin
        commit_s = ~flush_pend_r & (count_r != PTR_ZERO) & busy_r[head_r] & ready_r[head_r];
        {qj_ready, qj_value} = query(qj_RobId);
        {qk_ready, qk_value} = query(qk_RobId);
    end

    // Entry storage, pointers, retire payload and flush sequencing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r       <= {DEPTH{1'b0}};
            ready_r      <= {DEPTH{1'b0}};
            br_r         <= {DEPTH{1'b0}};
            mp_r         <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                rd_r[i]    <= 5'd0;
                value_r[i] <= 32'd0;
                tgt_r[i]   <= 32'd0;
            end
            head_r       <= PTR_ONE;
            tail_r       <= PTR_ONE;
            count_r      <= PTR_ZERO;
            flush_pend_r <= 1'b0;
            flush_pc_r   <= 32'd0;
            commit_valid <= 1'b0;
            commit_dest  <= 5'd0;
            commit_value <= 32'd0;
            commit_RobId <= PTR_ZERO;
            jump_flag    <= 1'b0;
            jump_pc      <= 32'd0;
        end else if (rdy) begin
            if (flush_pend_r) begin
                busy_r       <= {DEPTH{1'b0}};
                ready_r      <= {DEPTH{1'b0}};
                head_r       <= PTR_ONE;
                tail_r       <= PTR_ONE;
                count_r      <= PTR_ZERO;
                flush_pend_r <= 1'b0;
                commit_valid <= 1'b0;
                jump_flag    <= 1'b1;
                jump_pc      <= flush_pc_r;
            end else begin
                jump_flag <= 1'b0;
                // Slot 0 is never busy, so a tag-0 writeback drops out here too.
                if (cdb_valid && busy_r[cdb_RobId]) begin
                    ready_r[cdb_RobId] <= 1'b1;
                    value_r[cdb_RobId] <= cdb_value;
                    mp_r[cdb_RobId]    <= cdb_mispredict;
                    tgt_r[cdb_RobId]   <= cdb_target;
                end
                if (rename_valid) begin
                    busy_r[tail_r]  <= 1'b1;
                    ready_r[tail_r] <= 1'b0;
                    rd_r[tail_r]    <= issue_rd;
                    br_r[tail_r]    <= issue_is_branch;
                    mp_r[tail_r]    <= 1'b0;
                    tail_r          <= ptr_next(tail_r);
                end
                if (commit_s) begin
                    commit_valid   <= 1'b1;
                    commit_dest    <= rd_r[head_r];
                    commit_value   <= value_r[head_r];
                    commit_RobId   <= head_r;
                    busy_r[head_r] <= 1'b0;
                    head_r         <= ptr_next(head_r);
                    if (br_r[head_r] && mp_r[head_r]) begin
                        flush_pend_r <= 1'b1;
                        flush_pc_r   <= tgt_r[head_r];
                    end
                end else begin
                    commit_valid <= 1'b0;
                end
                case ({rename_valid, commit_s})
                    2'b10:   count_r <= count_r + PTR_ONE;
                    2'b01:   count_r <= count_r - PTR_ONE;
                    default: count_r <= count_r;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized scoreboard bench for reorder_buffer: an in-order instruction queue model
// predicts commits, flushes, occupancy and operand queries.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = 5'd0;
    logic        issue_is_branch = 1'b0;
    logic        rob_full, rename_valid;
    logic [3:0]  issue_RobId;
    logic        cdb_valid = 1'b0;
    logic [3:0]  cdb_RobId = 4'd0;
    logic [31:0] cdb_value = 32'd0;
    logic        cdb_mispredict = 1'b0;
    logic [31:0] cdb_target = 32'd0;
    logic [3:0]  qj_RobId = 4'd0, qk_RobId = 4'd0;
    logic        qj_ready, qk_ready;
    logic [31:0] qj_value, qk_value;
    logic        commit_valid;
    logic [4:0]  commit_dest;
    logic [31:0] commit_value;
    logic [3:0]  commit_RobId;
    logic        jump_flag;
    logic [31:0] jump_pc;

    reorder_buffer #(.ROB_LOG(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_branch(issue_is_branch),
        .rob_full(rob_full), .rename_valid(rename_valid), .issue_RobId(issue_RobId),
        .cdb_valid(cdb_valid), .cdb_RobId(cdb_RobId), .cdb_value(cdb_value),
        .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
        .qj_RobId(qj_RobId), .qk_RobId(qk_RobId),
        .qj_ready(qj_ready), .qj_value(qj_value), .qk_ready(qk_ready), .qk_value(qk_value),
        .commit_valid(commit_valid), .commit_dest(commit_dest), .commit_value(commit_value),
        .commit_RobId(commit_RobId), .jump_flag(jump_flag), .jump_pc(jump_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  rd;
        bit          br;
        bit          done;
        logic [31:0] val;
        bit          mp;
        logic [31:0] tgt;
    } ent_t;

    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  rd;
        logic [31:0] val;
    } cm_t;

    ent_t        rob_q[$];
    cm_t         exp_c[$];
    logic [31:0] exp_j[$];
    logic [3:0]  next_tag = 4'd1;
    bit          m_flush = 1'b0, m_jump = 1'b0, act_edge = 1'b0;
    logic [31:0] m_pc = 32'd0;
    ent_t        m_e;
    cm_t         m_c;
    int          checks = 0, errors = 0;
    bit          hold_v = 1'b0, hold_j = 1'b0;
    cm_t         hold_c;
    logic [31:0] hold_pc = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [32:0] q_exp(input logic [3:0] t);
        if (t == 4'd0) return 33'd0;
        foreach (rob_q[i]) if (rob_q[i].tag == t && rob_q[i].done) return {1'b1, rob_q[i].val};
        if (cdb_valid && cdb_RobId == t) return {1'b1, cdb_value};
        return 33'd0;
    endfunction

    // Reference model: program-order queue of in-flight instructions, updated per active edge.
    initial begin
        bit full_m, do_commit;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                rob_q.delete(); exp_c.delete(); exp_j.delete();
                next_tag = 4'd1; m_flush = 1'b0; m_jump = 1'b0; act_edge = 1'b0;
            end else if (!rdy) begin
                act_edge = 1'b0;
            end else begin
                act_edge = 1'b1;
                full_m = (rob_q.size() == 15) || m_flush || m_jump;
                if (m_flush) begin
                    rob_q.delete();
                    next_tag = 4'd1;
                    m_flush = 1'b0;
                    m_jump = 1'b1;
                    exp_j.push_back(m_pc);
                end else begin
                    m_jump = 1'b0;
                    do_commit = (rob_q.size() > 0) && rob_q[0].done;
                    if (do_commit) begin
                        m_e = rob_q.pop_front();
                        m_c.tag = m_e.tag; m_c.rd = m_e.rd; m_c.val = m_e.val;
                        exp_c.push_back(m_c);
                        if (m_e.br && m_e.mp) begin
                            m_flush = 1'b1;
                            m_pc = m_e.tgt;
                        end
                    end
                    if (cdb_valid) begin
                        foreach (rob_q[i]) if (rob_q[i].tag == cdb_RobId) begin
                            rob_q[i].done = 1'b1;
                            rob_q[i].val  = cdb_value;
                            rob_q[i].mp   = cdb_mispredict;
                            rob_q[i].tgt  = cdb_target;
                        end
                    end
                    if (issue_valid && !full_m) begin
                        m_e.tag = next_tag; m_e.rd = issue_rd; m_e.br = issue_is_branch;
                        m_e.done = 1'b0; m_e.val = 32'd0; m_e.mp = 1'b0; m_e.tgt = 32'd0;
                        rob_q.push_back(m_e);
                        next_tag = (next_tag == 4'd15) ? 4'd1 : next_tag + 4'd1;
                    end
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the model and the expected-response queues.
    always @(negedge clk) begin
        logic [32:0] qe;
        bit full_e;
        #2;
        if (!rst) begin
            hold_v = 1'b0; hold_j = 1'b0; hold_pc = 32'd0;
            hold_c.tag = 4'd0; hold_c.rd = 5'd0; hold_c.val = 32'd0;
        end else begin
            full_e = (rob_q.size() == 15) || m_flush || m_jump;
            chk("rob_full", rob_full, full_e);
            chk("rename_valid", rename_valid, issue_valid & ~full_e);
            chk("issue_RobId", issue_RobId, next_tag);
            qe = q_exp(qj_RobId);
            chk("qj_ready", qj_ready, qe[32]);
            chk("qj_value", qj_value, qe[31:0]);
            qe = q_exp(qk_RobId);
            chk("qk_ready", qk_ready, qe[32]);
            chk("qk_value", qk_value, qe[31:0]);
            if (act_edge) begin
                if (commit_valid) begin
                    if (exp_c.size() == 0) begin
                        chk("unexpected_commit", commit_valid, 32'd0);
                    end else begin
                        hold_c = exp_c.pop_front();
                        chk("commit_RobId", commit_RobId, hold_c.tag);
                        chk("commit_dest", commit_dest, hold_c.rd);
                        chk("commit_value", commit_value, hold_c.val);
                    end
                end else begin
                    chk("missing_commit", exp_c.size(), 32'd0);
                end
                hold_v = commit_valid;
                if (jump_flag) begin
                    if (exp_j.size() == 0) begin
                        chk("unexpected_jump", jump_flag, 32'd0);
                    end else begin
                        hold_pc = exp_j.pop_front();
                        chk("jump_pc", jump_pc, hold_pc);
                    end
                end else begin
                    chk("missing_jump", exp_j.size(), 32'd0);
                end
                hold_j = jump_flag;
            end else begin
                chk("hold_commit_valid", commit_valid, hold_v);
                chk("hold_jump_flag", jump_flag, hold_j);
                if (hold_v) begin
                    chk("hold_commit_RobId", commit_RobId, hold_c.tag);
                    chk("hold_commit_value", commit_value, hold_c.val);
                end
                if (hold_j) chk("hold_jump_pc", jump_pc, hold_pc);
            end
        end
    end

    task automatic set_in(input bit r, input bit iv, input logic [4:0] rd, input bit br,
                          input bit cv, input logic [3:0] ct, input logic [31:0] cval,
                          input bit cm, input logic [31:0] ctg);
        rdy = r; issue_valid = iv; issue_rd = rd; issue_is_branch = br;
        cdb_valid = cv; cdb_RobId = ct; cdb_value = cval; cdb_mispredict = cm; cdb_target = ctg;
        qj_RobId = 4'($urandom_range(0, 15));
        qk_RobId = cv ? ct : 4'($urandom_range(0, 15));
    endtask

    task automatic drive(input bit iv, input logic [4:0] rd, input bit br, input bit cv,
                         input logic [3:0] ct, input logic [31:0] cval, input bit cm,
                         input logic [31:0] ctg);
        @(negedge clk); #1;
        set_in(1'b1, iv, rd, br, cv, ct, cval, cm, ctg);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic rand_cycle(input int p_iss, input int p_wb, input int p_rdy);
        int idx[$];
        logic [3:0] t;
        @(negedge clk); #1;
        foreach (rob_q[i]) if (!rob_q[i].done) idx.push_back(i);
        if (idx.size() > 0 && $urandom_range(0, 7) != 0)
            t = rob_q[idx[$urandom_range(0, idx.size() - 1)]].tag;
        else
            t = 4'($urandom_range(0, 15));
        set_in($urandom_range(0, 99) < p_rdy, $urandom_range(0, 99) < p_iss, 5'($urandom),
               $urandom_range(0, 3) == 0, $urandom_range(0, 99) < p_wb, t, $urandom,
               $urandom_range(0, 2) == 0, $urandom);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1 rst = 1'b1; rdy = 1'b1;
        #1;
        chk("reset_commit_valid", commit_valid, 32'd0);
        chk("reset_jump_flag", jump_flag, 32'd0);
        chk("reset_issue_RobId", issue_RobId, 32'd1);
        // First allocation and retire
        drive(1'b1, 5'd5, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        drive(1'b0, 5'd0, 1'b0, 1'b1, 4'd1, 32'h1234, 1'b0, 32'd0);
        idle(2);
        // Out-of-order writeback, in-order retire
        for (int i = 0; i < 3; i++) drive(1'b1, 5'(i + 7), 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) drive(1'b0, 5'd0, 1'b0, 1'b1, 4'(4 - i), 32'(100 + i), 1'b0, 32'd0);
        idle(4);
        // Mispredicted branch with a younger entry behind it
        drive(1'b1, 5'd0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        drive(1'b1, 5'd1, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        drive(1'b1, 5'd3, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        drive(1'b0, 5'd0, 1'b0, 1'b1, 4'd6, 32'h44, 1'b1, 32'h80);
        drive(1'b0, 5'd0, 1'b0, 1'b1, 4'd5, 32'h7, 1'b0, 32'd0);
        idle(5);
        // Fill to capacity, then retire one and reuse the wrapped tag
        for (int i = 0; i < 16; i++) drive(1'b1, 5'(i), 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        drive(1'b1, 5'd9, 1'b0, 1'b1, 4'd1, 32'h55, 1'b0, 32'd0);
        drive(1'b1, 5'd10, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        drive(1'b1, 5'd11, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        // Stall across a pending commit
        drive(1'b0, 5'd0, 1'b0, 1'b1, 4'd2, 32'h66, 1'b0, 32'd0);
        drive(1'b0, 5'd0, 1'b0, 1'b1, 4'd3, 32'h77, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            set_in(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        end
        idle(3);
        for (int i = 0; i < 300; i++) rand_cycle(90, 15, 100);
        for (int i = 0; i < 700; i++) rand_cycle(60, 60, 85);
        // Asynchronous reset in the middle of traffic
        @(negedge clk); #1 rst = 1'b0;
        #1;
        chk("midreset_commit_valid", commit_valid, 32'd0);
        chk("midreset_jump_flag", jump_flag, 32'd0);
        chk("midreset_commit_value", commit_value, 32'd0);
        chk("midreset_issue_RobId", issue_RobId, 32'd1);
        chk("midreset_rob_full", rob_full, 32'd0);
        @(negedge clk); #1 rst = 1'b1;
        for (int i = 0; i < 700; i++) rand_cycle(50, 70, 90);
        for (int i = 0; i < 80; i++) rand_cycle(0, 100, 100);
        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
